tp_sram_ctrl: RTL and testbench

Parametrised two-port synchronous SRAM model. It replaces the single-port, asynchronous-read memory model used by the instruction and data paths of the RISC-V core. Port A is read/write with byte enables; port B is read-only. Both ports have registered reads, and a same-cycle write/read collision forwards the write data. An optional post-reset clear engine zeroes the array before the block accepts any access.

---
 rtl/tp_sram_pkg.sv | 31 +++
 rtl/tp_sram_clear_fsm.sv | 61 ++++++
 rtl/tp_sram_ctrl.sv | 132 +++++++++++++
 tb/tb_tp_sram_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tp_sram_pkg.sv
// Shared types and helpers for the two-port SRAM model.
// Holds the clear-engine state enum, byte-enable width and byte merge.
package tp_sram_pkg;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   // Widest word the merge helper handles; callers cast in and out.
   localparam int MAXW  = 1024;
   localparam int MAXBW = MAXW / 8;

   function automatic int be_width(input int dw);
      return dw / 8;
   endfunction

   function automatic logic [MAXW-1:0] merge(
      input logic [MAXW-1:0]  old_w,
      input logic [MAXW-1:0]  new_w,
      input logic [MAXBW-1:0] be
   );
      logic [MAXW-1:0] r;
      r = old_w;
      for (int i = 0; i < MAXBW; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/tp_sram_clear_fsm.sv
// Post-reset clear engine: walks the array writing zero, holding BUSY.
// Ports: clk, rst (sync, high), busy, wr_en/wr_addr/wr_data/wr_be.
module tp_sram_clear_fsm
   import tp_sram_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 12,
   parameter int DEPTH  = 4096,
   parameter bit EN     = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        busy,
   output logic                        wr_en,
   output logic [AWIDTH-1:0]           wr_addr,
   output logic [DWIDTH-1:0]           wr_data,
   output logic [be_width(DWIDTH)-1:0] wr_be
);

   localparam state_t RST_ST = EN ? CLEAR : READY;
   localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

   state_t            state, state_n;
   logic [AWIDTH-1:0] cnt, cnt_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RST_ST;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wr_en   = 1'b0;
      case (state)
         CLEAR: begin
            wr_en = 1'b1;
            if (cnt == LAST) begin
               state_n = READY;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = READY;
         end
      endcase
   end

   assign busy    = (state == CLEAR);
   assign wr_addr = cnt;
   assign wr_data = '0;
   assign wr_be   = '1;

endmodule

// File: rtl/tp_sram_ctrl.sv
// Two-port synchronous SRAM: port A r/w with byte enables, port B read.
// Registered reads, write-first A->B forwarding, optional clear engine.
// Ports: CLK, RST, A_CSN/A_WEN/A_ADDR/A_BE/A_DI/A_DOUT/A_VALID,
//        B_CSN/B_ADDR/B_DOUT/B_VALID, BUSY.
// Macro TP_SRAM_INIT_CLEAR_EN enables the post-reset clear engine.
module tp_sram_ctrl
   import tp_sram_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 12,
   parameter int DEPTH  = 4096,
   parameter     ROMDATA = ""
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        A_CSN,
   input  logic                        A_WEN,
   input  logic [AWIDTH-1:0]           A_ADDR,
   input  logic [be_width(DWIDTH)-1:0] A_BE,
   input  logic [DWIDTH-1:0]           A_DI,
   output logic [DWIDTH-1:0]           A_DOUT,
   output logic                        A_VALID,
   input  logic                        B_CSN,
   input  logic [AWIDTH-1:0]           B_ADDR,
   output logic [DWIDTH-1:0]           B_DOUT,
   output logic                        B_VALID,
   output logic                        BUSY
);

   localparam int BW = be_width(DWIDTH);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

`ifdef TP_SRAM_INIT_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic [DWIDTH-1:0] ram [DEPTH];

   function automatic logic [DWIDTH-1:0] mrg(
      input logic [DWIDTH-1:0] o,
      input logic [DWIDTH-1:0] n,
      input logic [BW-1:0]     be
   );
      return DWIDTH'(merge(MAXW'(o), MAXW'(n), MAXBW'(be)));
   endfunction

   logic              c_en;
   logic [AWIDTH-1:0] c_addr;
   logic [DWIDTH-1:0] c_data;
   logic [BW-1:0]     c_be;

   tp_sram_clear_fsm #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH),
      .DEPTH  (DEPTH),
      .EN     (CLR_EN)
   ) u_clr (
      .clk     (CLK),
      .rst     (RST),
      .busy    (BUSY),
      .wr_en   (c_en),
      .wr_addr (c_addr),
      .wr_data (c_data),
      .wr_be   (c_be)
   );

   logic a_acc, b_acc, a_in, b_in, fwd;
   logic [IW-1:0] a_idx, b_idx, w_idx;

   assign a_acc = !A_CSN && !BUSY && !RST;
   assign b_acc = !B_CSN && !BUSY && !RST;
   assign a_in  = {1'b0, A_ADDR} < DEPTH_W;
   assign b_in  = {1'b0, B_ADDR} < DEPTH_W;
   assign a_idx = A_ADDR[IW-1:0];
   assign b_idx = B_ADDR[IW-1:0];

   logic              wr_en;
   logic [AWIDTH-1:0] wr_addr;
   logic [DWIDTH-1:0] wr_data;
   logic [BW-1:0]     wr_be;

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = A_ADDR;
      wr_data = A_DI;
      wr_be   = A_BE;
      if (c_en) begin
         wr_en   = !RST;
         wr_addr = c_addr;
         wr_data = c_data;
         wr_be   = c_be;
      end else begin
         wr_en = a_acc && !A_WEN && a_in;
      end
   end

   assign w_idx = wr_addr[IW-1:0];
   assign fwd   = wr_en && (wr_addr == B_ADDR);

   always_ff @(posedge CLK) begin
      if (wr_en) ram[w_idx] <= mrg(ram[w_idx], wr_data, wr_be);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         A_DOUT  <= '0;
         B_DOUT  <= '0;
         A_VALID <= 1'b0;
         B_VALID <= 1'b0;
      end else begin
         A_VALID <= 1'b0;
         B_VALID <= 1'b0;
         if (a_acc && A_WEN) begin
            A_VALID <= 1'b1;
            A_DOUT  <= a_in ? ram[a_idx] : '0;
         end
         if (b_acc) begin
            B_VALID <= 1'b1;
            if (!b_in)
               B_DOUT <= '0;
            else if (fwd)
               B_DOUT <= mrg(ram[b_idx], wr_data, wr_be);
            else
               B_DOUT <= ram[b_idx];
         end
      end
   end

endmodule

// File: tb/tb_tp_sram_ctrl.sv
// Self-checking bench for tp_sram_ctrl (DEPTH=16, AWIDTH=5).
// Scoreboard queues hold expected read data per port.
module tb_tp_sram_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DP = 16;

`ifdef TP_SRAM_INIT_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif
   localparam int EXP_BUSY = CLR ? DP : 0;

   logic          CLK = 1'b0;
   logic          RST;
   logic          A_CSN, A_WEN;
   logic [AW-1:0] A_ADDR;
   logic [3:0]    A_BE;
   logic [DW-1:0] A_DI, A_DOUT;
   logic          A_VALID;
   logic          B_CSN;
   logic [AW-1:0] B_ADDR;
   logic [DW-1:0] B_DOUT;
   logic          B_VALID, BUSY;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] model [32];
   logic [DW-1:0] qa [$];
   logic [DW-1:0] qb [$];

   tp_sram_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DP)) dut (
      .CLK(CLK), .RST(RST),
      .A_CSN(A_CSN), .A_WEN(A_WEN), .A_ADDR(A_ADDR), .A_BE(A_BE),
      .A_DI(A_DI), .A_DOUT(A_DOUT), .A_VALID(A_VALID),
      .B_CSN(B_CSN), .B_ADDR(B_ADDR), .B_DOUT(B_DOUT),
      .B_VALID(B_VALID), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   function automatic logic [DW-1:0] bmerge(
      input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [3:0] be);
      logic [DW-1:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   // Scoreboard: pop one expected word per VALID pulse.
   always @(negedge CLK) begin
      logic [DW-1:0] e;
      if (A_VALID === 1'b1) begin
         tests++;
         if (qa.size() == 0) begin
            fails++;
            $display("FAIL a_valid_unexpected: A_VALID=1 with nothing pending, required 0");
         end else begin
            e = qa.pop_front();
            if (A_DOUT !== e) begin
               fails++;
               $display("FAIL a_dout: got %h required %h", A_DOUT, e);
            end
         end
      end
      if (B_VALID === 1'b1) begin
         tests++;
         if (qb.size() == 0) begin
            fails++;
            $display("FAIL b_valid_unexpected: B_VALID=1 with nothing pending, required 0");
         end else begin
            e = qb.pop_front();
            if (B_DOUT !== e) begin
               fails++;
               $display("FAIL b_dout: got %h required %h", B_DOUT, e);
            end
         end
      end
   end

   // One cycle of stimulus; returns the VALIDs seen before driving.
   task automatic drive(input bit ae, input bit aw, input logic [AW-1:0] aa,
                        input logic [3:0] be, input logic [DW-1:0] di,
                        input bit ben, input logic [AW-1:0] ba,
                        output logic av, output logic bv);
      @(negedge CLK);
      av = A_VALID;
      bv = B_VALID;
      A_CSN = ~ae; A_WEN = ~aw; A_ADDR = aa; A_BE = be; A_DI = di;
      B_CSN = ~ben; B_ADDR = ba;
      if (!RST && !BUSY) begin
         if (ae && aw && aa < DP) model[aa] = bmerge(model[aa], di, be);
         if (ae && !aw) qa.push_back(aa < DP ? model[aa] : '0);
         if (ben) qb.push_back(ba < DP ? model[ba] : '0);
      end
   endtask

   task automatic idle();
      logic x, y;
      drive(0, 0, '0, '0, '0, 0, '0, x, y);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 4 && (qa.size() != 0 || qb.size() != 0); i++)
         @(negedge CLK);
      @(negedge CLK);
      tests++;
      if (qa.size() != 0 || qb.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: pending a=%0d b=%0d, required 0 0",
                  nm, qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   task automatic release_and_count(output int n);
      @(negedge CLK);
      RST = 1'b0;
      A_CSN = 1'b1;
      n = 0;
      while (BUSY === 1'b1 && n < 64) begin
         A_CSN = 1'b0; A_WEN = 1'b1; A_ADDR = 5'd5;
         B_CSN = 1'b0; B_ADDR = 5'd5;
         n++;
         @(negedge CLK);
      end
      A_CSN = 1'b1;
      B_CSN = 1'b1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      tests += 5;
      if (A_DOUT !== '0) begin fails++; $display("FAIL rst_a_dout: got %h required 0", A_DOUT); end
      if (B_DOUT !== '0) begin fails++; $display("FAIL rst_b_dout: got %h required 0", B_DOUT); end
      if (A_VALID !== 1'b0) begin fails++; $display("FAIL rst_a_valid: got %b required 0", A_VALID); end
      if (B_VALID !== 1'b0) begin fails++; $display("FAIL rst_b_valid: got %b required 0", B_VALID); end
      if (BUSY !== CLR) begin fails++; $display("FAIL rst_busy: got %b required %b", BUSY, CLR); end
   endtask

   task automatic test_clear();
      int n;
      logic av0, av1, av2, bv;
      release_and_count(n);
      tests++;
      if (n != EXP_BUSY) begin
         fails++;
         $display("FAIL clear_busy_cycles: got %0d required %0d", n, EXP_BUSY);
      end
      if (CLR) for (int i = 0; i < 32; i++) model[i] = '0;
      if (!CLR) drive(1, 1, 5'd5, 4'hF, 32'h0, 0, '0, av0, bv);
      drive(1, 0, 5'd5, 4'h0, '0, 0, '0, av0, bv);
      drive(0, 0, '0, '0, '0, 0, '0, av1, bv);
      drive(0, 0, '0, '0, '0, 0, '0, av2, bv);
      tests += 2;
      if (av1 !== 1'b1) begin fails++; $display("FAIL clear_read_valid: got %b required 1", av1); end
      if (av2 !== 1'b0) begin fails++; $display("FAIL clear_valid_pulse: got %b required 0", av2); end
      drain("clear");
   endtask

   task automatic test_byte_enable();
      logic av, bv;
      drive(1, 1, 5'd3, 4'hF, 32'h11223344, 0, '0, av, bv);
      drive(1, 1, 5'd3, 4'b0101, 32'hAABBCCDD, 0, '0, av, bv);
      drive(1, 0, 5'd3, 4'h0, '0, 0, '0, av, bv);
      drive(1, 1, 5'd3, 4'h0, 32'hFFFFFFFF, 0, '0, av, bv);
      drive(1, 0, 5'd3, 4'h0, '0, 0, '0, av, bv);
      idle();
      drain("byte_en");
      tests++;
      if (A_DOUT !== 32'h11BB33DD) begin
         fails++;
         $display("FAIL byte_en_hold: got %h required %h", A_DOUT, 32'h11BB33DD);
      end
   endtask

   task automatic test_collision();
      logic av, bv;
      drive(1, 1, 5'd7, 4'hF, 32'h01020304, 0, '0, av, bv);
      drive(1, 1, 5'd7, 4'hF, 32'hDEADBEEF, 1, 5'd7, av, bv);
      drive(0, 0, '0, '0, '0, 0, '0, av, bv);
      tests++;
      if (bv !== 1'b1) begin fails++; $display("FAIL collision_valid: got %b required 1", bv); end
      drain("collision");
      tests++;
      if (B_DOUT !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL collision_hold: got %h required %h", B_DOUT, 32'hDEADBEEF);
      end
   endtask

   task automatic test_back_to_back();
      logic av;
      logic [4:0] v;
      for (int i = 0; i < 3; i++)
         drive(1, 1, AW'(i), 4'hF, DW'(32'h10 + i), 0, '0, av, v[0]);
      idle();
      drive(1, 0, 5'd2, '0, '0, 1, 5'd0, av, v[0]);
      drive(1, 0, 5'd1, '0, '0, 1, 5'd1, av, v[1]);
      drive(1, 0, 5'd0, '0, '0, 1, 5'd2, av, v[2]);
      drive(0, 0, '0, '0, '0, 0, '0, av, v[3]);
      drive(0, 0, '0, '0, '0, 0, '0, av, v[4]);
      tests++;
      if (v !== 5'b01110) begin
         fails++;
         $display("FAIL b2b_valid_train: got %b required %b", v, 5'b01110);
      end
      drain("b2b");
   endtask

   task automatic test_out_of_range();
      logic av, bv;
      drive(1, 1, 5'd4, 4'hF, 32'hCAFEF00D, 0, '0, av, bv);
      drive(1, 1, 5'd20, 4'hF, 32'h12345678, 0, '0, av, bv);
      drive(1, 0, 5'd20, '0, '0, 1, 5'd20, av, bv);
      drive(1, 0, 5'd4, '0, '0, 1, 5'd4, av, bv);
      drive(1, 0, 5'd20, '0, '0, 0, '0, av, bv);
      drive(0, 0, '0, '0, '0, 0, '0, av, bv);
      tests++;
      if (av !== 1'b1) begin fails++; $display("FAIL oor_valid: got %b required 1", av); end
      drain("oor");
      tests++;
      if (B_DOUT !== 32'hCAFEF00D) begin
         fails++;
         $display("FAIL oor_ram4: got %h required %h", B_DOUT, 32'hCAFEF00D);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic av, bv;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      repeat (8) idle();
      @(negedge CLK);
      RST = 1'b1;
      A_CSN = 1'b0; A_WEN = 1'b1; A_ADDR = 5'd3;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         tests += 2;
         if (BUSY !== CLR) begin fails++; $display("FAIL mid_rst_busy: got %b required %b", BUSY, CLR); end
         if (A_VALID !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b required 0", A_VALID); end
      end
      A_CSN = 1'b1;
      release_and_count(n);
      tests++;
      if (n != EXP_BUSY) begin
         fails++;
         $display("FAIL mid_busy_cycles: got %0d required %0d", n, EXP_BUSY);
      end
      if (CLR) for (int i = 0; i < 32; i++) model[i] = '0;
      drive(1, 0, 5'd7, '0, '0, 1, 5'd3, av, bv);
      idle();
      drain("mid");
   endtask

   initial begin
      RST = 1'b1;
      A_CSN = 1'b1; A_WEN = 1'b1; A_ADDR = '0; A_BE = '0; A_DI = '0;
      B_CSN = 1'b1; B_ADDR = '0;
      for (int i = 0; i < 32; i++) model[i] = 'x;
      test_reset();
      test_clear();
      test_byte_enable();
      test_collision();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
